user_leds_driver: RTL and testbench



---
 rtl/user_leds_driver.sv | 99 +++++++++
 tb/tb_user_leds_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/user_leds_driver.sv
// Register-mapped driver for the eight board user LEDs: pattern, per-LED blink,
// programmable blink half-period and global PWM brightness, with readback.
module user_leds_driver #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic [7:0]  user_led
);

    localparam logic [7:0] LED_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]  data_q, blink_q, duty_q;
    logic [31:0] period_q;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_phase_q, blink_phase_d;
    logic [7:0]  pwm_cnt_q;
    logic [7:0]  led_q, led_d;

    logic [1:0]  sel;
    logic        wr_data, wr_blink, wr_period, wr_duty;
    logic [31:0] period_eff;
    logic        pwm_on;
    logic [7:0]  lit;
    logic        unused_addr;

    assign sel         = Addr[3:2];
    assign unused_addr = ^{Addr[7:4], Addr[1:0]};
    assign wr_data     = WE && (sel == 2'd0);
    assign wr_blink    = WE && (sel == 2'd1);
    assign wr_period   = WE && (sel == 2'd2);
    assign wr_duty     = WE && (sel == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= 8'h00;
            blink_q  <= 8'h00;
            period_q <= DEFAULT_PERIOD;
            duty_q   <= 8'hFF;
        end else begin
            if (wr_data)   data_q   <= Din[7:0];
            if (wr_blink)  blink_q  <= Din[7:0];
            if (wr_period) period_q <= Din;
            if (wr_duty)   duty_q   <= Din[7:0];
        end
    end

    // A PERIOD write restarts the blink cycle lit, overriding any wrap that cycle.
    always_comb begin
        period_eff    = (period_q == 32'd0) ? 32'd1 : period_q;
        blink_cnt_d   = blink_cnt_q + 32'd1;
        blink_phase_d = blink_phase_q;
        if (wr_period) begin
            blink_cnt_d   = 32'd0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q >= period_eff - 32'd1) begin
            blink_cnt_d   = 32'd0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_comb begin
        pwm_on = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
        lit    = data_q & (~blink_q | {8{blink_phase_q}}) & {8{pwm_on}};
        led_d  = ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q   <= 32'd0;
            blink_phase_q <= 1'b1;
            pwm_cnt_q     <= 8'd0;
            led_q         <= LED_OFF;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_q + 8'd1;
            led_q         <= led_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            2'd0:    Dout = {24'd0, data_q};
            2'd1:    Dout = {24'd0, blink_q};
            2'd2:    Dout = period_q;
            default: Dout = {24'd0, duty_q};
        endcase
    end

    assign user_led = led_q;

endmodule

// File: tb/tb_user_leds_driver.sv
// Bench for user_leds_driver: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_user_leds_driver;

    localparam logic [31:0] DEFP = 32'd25_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Addr = 8'h00;
    logic        WE = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic [7:0]  user_led;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    user_leds_driver #(.DEFAULT_PERIOD(DEFP), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din),
        .Dout(Dout), .user_led(user_led)
    );

    always #5 clk = ~clk;

    // Reference model: blink phase and PWM position derived from edge counts
    // since the last restart (reset or PERIOD write).
    logic [7:0]  m_data = 8'h00, m_blink = 8'h00, m_duty = 8'hFF, m_led = 8'hFF;
    logic [31:0] m_period = DEFP;
    longint      m_k = 0, m_pk = 0;

    always @(posedge clk or negedge reset) begin
        longint     peff;
        bit         phase, on;
        logic [7:0] lit;
        if (!reset) begin
            m_data = 8'h00; m_blink = 8'h00; m_duty = 8'hFF; m_period = DEFP;
            m_led = 8'hFF; m_k = 0; m_pk = 0;
        end else begin
            peff  = (m_period == 32'd0) ? 1 : longint'(m_period);
            phase = ((m_k / peff) % 2) == 0;
            on    = (m_duty == 8'hFF) || ((m_pk % 256) < longint'(m_duty));
            lit   = m_data & (~m_blink | {8{phase}}) & {8{on}};
            m_led = ~lit;
            m_k++;
            m_pk++;
            if (WE) begin
                case (Addr[3:2])
                    2'd0: m_data = Din[7:0];
                    2'd1: m_blink = Din[7:0];
                    2'd2: begin m_period = Din; m_k = 0; end
                    default: m_duty = Din[7:0];
                endcase
            end
        end
    end

    function automatic logic [31:0] exp_dout(input logic [7:0] a);
        case (a[3:2])
            2'd0:    return {24'd0, m_data};
            2'd1:    return {24'd0, m_blink};
            2'd2:    return m_period;
            default: return {24'd0, m_duty};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_led", {24'd0, user_led}, {24'd0, m_led});
            chk("model_dout", Dout, exp_dout(Addr));
        end
    end

    task automatic drive(input logic we, input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        WE = we; Addr = a; Din = d;
    endtask

    // Write lands on the next edge; returns 2ns after that edge with WE low.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        drive(1'b0, a, 32'd0);
    endtask

    initial begin
        int lit_n, off_n;
        logic b;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        Addr = 8'h00; #1 chk("rst_data", Dout, 32'd0);
        Addr = 8'h04; #1 chk("rst_blink", Dout, 32'd0);
        Addr = 8'h08; #1 chk("rst_period", Dout, DEFP);
        Addr = 8'h0C; #1 chk("rst_duty", Dout, 32'h0000_00FF);
        chk("rst_led", {24'd0, user_led}, 32'h0000_00FF);
        chk_en = 1'b1;
        @(posedge clk); #3 reset = 1'b1;

        // DATA write latency and width truncation
        wr(8'h00, 32'h0000_00A5);
        #1 chk("data_rd", Dout, 32'h0000_00A5);
        @(posedge clk); #1 chk("data_led", {24'd0, user_led}, 32'h0000_005A);
        wr(8'h00, 32'hFFFF_FF3C);
        #1 chk("data_trunc", Dout, 32'h0000_003C);

        // Blink with PERIOD=4, starting lit
        wr(8'h04, 32'h1);
        wr(8'h00, 32'h1);
        wr(8'h08, 32'd4);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            b = ((i / 4) % 2) == 1;
            chk("blink4", {24'd0, user_led}, {24'd0, 7'h7F, b});
        end

        // PERIOD=0 toggles every cycle; PERIOD=10 written on a wrap restarts lit
        wr(8'h08, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            b = (i % 2) == 1;
            chk("blink0", {24'd0, user_led}, {24'd0, 7'h7F, b});
        end
        wr(8'h08, 32'd10);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            b = (i >= 10);
            chk("blink10", {24'd0, user_led}, {24'd0, 7'h7F, b});
        end

        // PWM duty: 0x40 -> 64 of 256, 0 -> never, 0xFF -> always
        wr(8'h04, 32'h0);
        wr(8'h00, 32'hFF);
        wr(8'h0C, 32'h40);
        lit_n = 0; off_n = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (user_led == 8'h00) lit_n++;
            if (user_led == 8'hFF) off_n++;
        end
        chk("pwm40_on", lit_n, 64);
        chk("pwm40_off", off_n, 192);
        wr(8'h0C, 32'h00);
        lit_n = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (user_led != 8'hFF) lit_n++;
        end
        chk("pwm00_on", lit_n, 0);
        wr(8'h0C, 32'hFF);
        lit_n = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            if (user_led == 8'h00) lit_n++;
        end
        chk("pwmff_on", lit_n, 256);

        // Asynchronous reset mid-blink
        wr(8'h04, 32'h1);
        wr(8'h08, 32'd3);
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("arst_led", {24'd0, user_led}, 32'h0000_00FF);
        Addr = 8'h08; #1 chk("arst_period", Dout, DEFP);
        Addr = 8'h04; #1 chk("arst_blink", Dout, 32'd0);
        @(posedge clk); #3 reset = 1'b1;
        wr(8'h04, 32'h1);
        wr(8'h00, 32'h1);
        @(posedge clk); #1 chk("arst_restart", {24'd0, user_led}, 32'h0000_00FE);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0]  a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = 8'($urandom);
            d = $urandom;
            if (a[3:2] == 2'd2 && $urandom_range(0, 9) != 0) d = $urandom_range(0, 12);
            if (r < 30) drive(1'b1, a, d);
            else        drive(1'b0, a, d);
            if ((i % 700) == 350) begin
                @(posedge clk); #3 reset = 1'b0;
                #4 reset = 1'b1;
            end
        end
        drive(1'b0, 8'h00, 32'd0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
